tea_regfile16: RTL and testbench
================================

# tea_regfile16

16-entry × WIDTH register bank for the TinyEncrypt datapath; sits directly downstream of `decoder4to16` and uses its 16-bit one-hot output as the write select. It validates the select, writes a single word per cycle and provides two registered read ports with write-first forwarding. Per-entry "written" tracking, a populated-entry count and a sticky select-error flag let the round controller know when key and data words are loaded.

## Interface
Parameters:
- `WIDTH`, default 32: data word width.

Ports:
- `CLK`, in, 1: sole clock; all state updates on the rising edge.
- `RST_N`, in, 1: asynchronous, active-low reset.
- `WE`, in, 16: one-hot write select from `decoder4to16` `OUT`.
- `WDATA`, in, `WIDTH`: write data.
- `RA0`, in, 4: read address, port 0.
- `RA1`, in, 4: read address, port 1.
- `RD0`, out, `WIDTH`: read data, port 0, registered.
- `RD1`, out, `WIDTH`: read data, port 1, registered.
- `RV0`, out, 1: entry `RA0` was written since the last reset or clear; registered alongside `RD0`.
- `RV1`, out, 1: same as `RV0`, for port 1.
- `CLR`, in, 1: synchronous clear of all written flags; data is kept.
- `ERR`, out, 1: sticky flag; a multi-hot `WE` has been seen.
- `ERR_CLR`, in, 1: synchronous clear of `ERR`.
- `WCOUNT`, out, 5: number of entries with the written flag set (0–16).

## Operation
- Classify `WE` each cycle:
  - zero: idle, no write.
  - exactly one bit set: write `WDATA` to entry i and set `written[i]`.
  - two or more bits set: no entry is written; `ERR` is set.
- `WCOUNT` tracks the number of set `written` bits:
  - +1 only when the written entry's flag was previously 0.
  - A rewrite of an already-written entry leaves `WCOUNT` unchanged.
- `CLR`:
  - Clears all `written` flags and sets `WCOUNT` to 0.
  - If `CLR` and a valid one-hot write occur in the same cycle, the write's entry ends with flag 1 and `WCOUNT` = 1. Its data is written.
- `ERR_CLR`:
  - Clears `ERR`.
  - If a multi-hot `WE` occurs in the same cycle, set wins and `ERR` stays 1.
- Read ports:
  - Both ports sample `RA0`/`RA1` every cycle; reads are unconditional.
  - Forwarding: if a valid one-hot write targets the read address in the same cycle, `RD` gets `WDATA` and `RV` = 1.
  - A concurrent `CLR` does not suppress forwarding, because the write wins for that entry.
  - Both ports may read the same address.
- A multi-hot `WE` is never forwarded. `RD`/`RV` return the stored contents.
- Reset (asynchronous, any time including mid-load):
  - all entries → 0, `written` → 0, `RD0`/`RD1` → 0, `RV0`/`RV1` → 0, `ERR` → 0, `WCOUNT` → 0.
- No internal state machine beyond the flags and counter. The block always accepts `WE` and has no backpressure.

## Timing
- Write latency is 1 cycle: data is visible in the array after the edge at which `WE` is one-hot.
- Read latency is 1 cycle: `RD`/`RV` reflect `RA` and `WE` as sampled at edge n, valid after edge n.
- `ERR` and `WCOUNT` update at the same edge as the triggering write.
- The `WE` classification path is purely combinational and must close in one cycle together with the decoder feeding it.
- `WCOUNT` never exceeds 16. It cannot wrap, because an increment requires a previously clear flag.

## Structure
- Shared package `tea_pkg` holds:
  - `NREGS` = 16
  - `ADDR_W` = 4
  - `CNT_W` = 5
  - the default `WIDTH` = 32
- Sub-module `onehot_check`: input 16-bit vector; outputs `zero`, `one`, `multi` and a 4-bit encoded `idx`. `idx` is valid only when `one` = 1.
- The top level holds:
  - the array
  - the written flags
  - the counter
  - the read registers
  - the forwarding muxes

## Test plan
- Reset, then write entry 5 with `WE`=0x0020 and `WDATA`=0xDEADBEEF, with `RA0`=5 in the same cycle → next cycle `RD0`=0xDEADBEEF (forwarded), `RV0`=1, `WCOUNT`=1.
- Write entries 0–15 in sequence, then rewrite entry 3 → `WCOUNT` reaches 16 and stays 16; `RA1`=3 returns the new data.
- `WE`=0x0180 (multi-hot), `WDATA`=0x12345678 → no entry changes, `ERR`=1 and stays 1. Assert `ERR_CLR` together with another multi-hot `WE` → `ERR` stays 1. Assert `ERR_CLR` alone → `ERR`=0.
- With 4 entries written, assert `CLR` together with `WE`=0x0004 → `WCOUNT`=1, entry 2 `RV`=1, entry 0 `RV`=0 but data retained.
- Deassert `RST_N` asynchronously mid-sequence after 7 writes → all outputs 0 immediately, without waiting for a clock edge; reads of any address return `RD`=0, `RV`=0.
- Both ports read address 9 while `WE`=0x0200 writes 0xA5A5A5A5 → `RD0` = `RD1` = 0xA5A5A5A5 and `RV0` = `RV1` = 1 the next cycle.

Source files
------------

// File: rtl/tea_pkg.sv
// Shared constants for the TinyEncrypt register bank.
package tea_pkg;

  localparam int unsigned NREGS     = 16;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned DEF_WIDTH = 32;

endpackage

// File: rtl/onehot_check.sv
// Classifies a 16-bit select as zero, one-hot or multi-hot and encodes the one-hot index.
module onehot_check
  import tea_pkg::*;
(
  input  logic [NREGS-1:0]  vec,
  output logic              zero,
  output logic              one,
  output logic              multi,
  output logic [ADDR_W-1:0] idx
);

  logic [NREGS-1:0] vec_m1;

  always_comb begin
    vec_m1 = vec - NREGS'(1);
    zero   = (vec == '0);
    // Clearing the lowest set bit leaves nothing only for a single set bit
    one    = !zero && ((vec & vec_m1) == '0);
    multi  = !zero && !one;
    idx    = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (vec[i]) idx = ADDR_W'(i);
    end
  end

endmodule

// File: rtl/tea_regfile16.sv
// 16-entry register bank with one-hot write select, written tracking and two
// registered, write-first read ports.
module tea_regfile16
  import tea_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NREGS-1:0]  WE,
  input  logic [WIDTH-1:0]  WDATA,
  input  logic [ADDR_W-1:0] RA0,
  input  logic [ADDR_W-1:0] RA1,
  output logic [WIDTH-1:0]  RD0,
  output logic [WIDTH-1:0]  RD1,
  output logic              RV0,
  output logic              RV1,
  input  logic              CLR,
  output logic              ERR,
  input  logic              ERR_CLR,
  output logic [CNT_W-1:0]  WCOUNT
);

  logic              we_zero, we_one, we_multi;
  logic [ADDR_W-1:0] we_idx;

  logic [WIDTH-1:0]  mem_q [NREGS];
  logic [NREGS-1:0]  written_q, written_d;
  logic [CNT_W-1:0]  wcount_q, wcount_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  rd0_q, rd0_d, rd1_q, rd1_d;
  logic              rv0_q, rv0_d, rv1_q, rv1_d;

  onehot_check u_onehot_check (
    .vec   (WE),
    .zero  (we_zero),
    .one   (we_one),
    .multi (we_multi),
    .idx   (we_idx)
  );

  always_comb begin
    written_d = CLR ? '0 : written_q;
    if (we_one) written_d[we_idx] = 1'b1;

    wcount_d = wcount_q;
    if (CLR) begin
      wcount_d = we_one ? CNT_W'(1) : '0;
    end else if (we_one && !written_q[we_idx]) begin
      wcount_d = wcount_q + CNT_W'(1);
    end

    // A multi-hot select in the same cycle beats the clear
    err_d = we_multi || (err_q && !ERR_CLR);

    // Write-first: a valid write to the read address is forwarded
    if (we_one && (we_idx == RA0)) begin
      rd0_d = WDATA;
      rv0_d = 1'b1;
    end else begin
      rd0_d = mem_q[RA0];
      rv0_d = written_q[RA0];
    end
    if (we_one && (we_idx == RA1)) begin
      rd1_d = WDATA;
      rv1_d = 1'b1;
    end else begin
      rd1_d = mem_q[RA1];
      rv1_d = written_q[RA1];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
      written_q <= '0;
      wcount_q  <= '0;
      err_q     <= 1'b0;
      rd0_q     <= '0;
      rd1_q     <= '0;
      rv0_q     <= 1'b0;
      rv1_q     <= 1'b0;
    end else begin
      if (we_one) mem_q[we_idx] <= WDATA;
      written_q <= written_d;
      wcount_q  <= wcount_d;
      err_q     <= err_d;
      rd0_q     <= rd0_d;
      rd1_q     <= rd1_d;
      rv0_q     <= rv0_d;
      rv1_q     <= rv1_d;
    end
  end

  assign RD0    = rd0_q;
  assign RD1    = rd1_q;
  assign RV0    = rv0_q;
  assign RV1    = rv1_q;
  assign ERR    = err_q;
  assign WCOUNT = wcount_q;

endmodule

// File: tb/tb_tea_regfile16.sv
// Directed bench for tea_regfile16: writes, forwarding, error flag, clear and async reset.
module tb_tea_regfile16;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] WE;
  logic [31:0] WDATA;
  logic [3:0]  RA0, RA1;
  logic [31:0] RD0, RD1;
  logic        RV0, RV1;
  logic        CLR, ERR, ERR_CLR;
  logic [4:0]  WCOUNT;

  int npass = 0;
  int ntotal = 0;

  tea_regfile16 #(.WIDTH(32)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .WE      (WE),
    .WDATA   (WDATA),
    .RA0     (RA0),
    .RA1     (RA1),
    .RD0     (RD0),
    .RD1     (RD1),
    .RV0     (RV0),
    .RV1     (RV1),
    .CLR     (CLR),
    .ERR     (ERR),
    .ERR_CLR (ERR_CLR),
    .WCOUNT  (WCOUNT)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd0"}, RD0, 32'h0);
    chk({tag, "_rd1"}, RD1, 32'h0);
    chk({tag, "_rv0"}, 32'(RV0), 32'h0);
    chk({tag, "_rv1"}, 32'(RV1), 32'h0);
    chk({tag, "_err"}, 32'(ERR), 32'h0);
    chk({tag, "_wcount"}, 32'(WCOUNT), 32'h0);
  endtask

  initial begin
    RST_N = 1'b0; WE = '0; WDATA = '0; RA0 = '0; RA1 = '0; CLR = 1'b0; ERR_CLR = 1'b0;
    #3;
    chk_all_zero("reset");
    step();
    RST_N = 1'b1;

    // Entry 5 write with same-cycle read: forwarded
    WE = 16'h0020; WDATA = 32'hDEADBEEF; RA0 = 4'd5; RA1 = 4'd0;
    step();
    chk("fwd5_rd0", RD0, 32'hDEADBEEF);
    chk("fwd5_rv0", 32'(RV0), 32'h1);
    chk("fwd5_rd1", RD1, 32'h0);
    chk("fwd5_rv1", 32'(RV1), 32'h0);
    chk("fwd5_wcount", 32'(WCOUNT), 32'd1);

    // Fill all entries; entry 5 already counted
    for (int i = 0; i < 16; i++) begin
      WE = 16'h1 << i; WDATA = 32'h1000_0000 + 32'(i);
      step();
      chk("fill_wcount", 32'(WCOUNT), (i < 5) ? 32'(i + 2) : 32'(i + 1));
    end
    WE = 16'h0008; WDATA = 32'hCAFE0003; RA1 = 4'd3;
    step();
    chk("rewrite3_fwd_rd1", RD1, 32'hCAFE0003);
    chk("rewrite3_wcount", 32'(WCOUNT), 32'd16);
    WE = '0;
    step();
    chk("rewrite3_rd1", RD1, 32'hCAFE0003);
    chk("rewrite3_rv1", 32'(RV1), 32'h1);
    chk("full_wcount", 32'(WCOUNT), 32'd16);

    // Multi-hot: nothing written, nothing forwarded, ERR sticky
    WE = 16'h0180; WDATA = 32'h12345678; RA0 = 4'd7; RA1 = 4'd8;
    step();
    chk("multi_err", 32'(ERR), 32'h1);
    chk("multi_rd0", RD0, 32'h1000_0007);
    chk("multi_rd1", RD1, 32'h1000_0008);
    chk("multi_wcount", 32'(WCOUNT), 32'd16);
    WE = '0;
    step();
    chk("multi_err_sticky", 32'(ERR), 32'h1);
    chk("multi_stored_rd0", RD0, 32'h1000_0007);
    chk("multi_stored_rd1", RD1, 32'h1000_0008);
    ERR_CLR = 1'b1; WE = 16'h0003;
    step();
    chk("errclr_vs_multi", 32'(ERR), 32'h1);
    WE = '0;
    step();
    chk("errclr_alone", 32'(ERR), 32'h0);
    ERR_CLR = 1'b0;

    // Clear, load 4 entries, then clear together with a write to entry 2
    CLR = 1'b1;
    step();
    chk("clr_wcount", 32'(WCOUNT), 32'd0);
    CLR = 1'b0;
    for (int i = 0; i < 4; i++) begin
      WE = 16'h1 << i; WDATA = 32'hA0 + 32'(i);
      step();
    end
    chk("load4_wcount", 32'(WCOUNT), 32'd4);
    CLR = 1'b1; WE = 16'h0004; WDATA = 32'hB2; RA0 = 4'd2; RA1 = 4'd0;
    step();
    chk("clrwr_fwd_rd0", RD0, 32'hB2);
    chk("clrwr_fwd_rv0", 32'(RV0), 32'h1);
    chk("clrwr_wcount", 32'(WCOUNT), 32'd1);
    CLR = 1'b0; WE = '0;
    step();
    chk("clrwr_rd0", RD0, 32'hB2);
    chk("clrwr_rv0", 32'(RV0), 32'h1);
    chk("clrwr_rd1_kept", RD1, 32'hA0);
    chk("clrwr_rv1", 32'(RV1), 32'h0);

    // Seven more writes, then asynchronous reset mid-cycle
    for (int i = 4; i < 11; i++) begin
      WE = 16'h1 << i; WDATA = 32'h5000_0000 + 32'(i);
      step();
    end
    WE = '0; RA0 = 4'd4; RA1 = 4'd2;
    chk("load7_wcount", 32'(WCOUNT), 32'd8);
    step();
    chk("load7_rd0", RD0, 32'h5000_0004);
    #2;
    RST_N = 1'b0;
    #1;
    chk_all_zero("async_rst");
    step();
    RST_N = 1'b1;
    RA1 = 4'd10;
    step();
    chk_all_zero("post_rst");

    // Both ports on one address while it is written
    WE = 16'h0200; WDATA = 32'hA5A5A5A5; RA0 = 4'd9; RA1 = 4'd9;
    step();
    chk("dual9_rd0", RD0, 32'hA5A5A5A5);
    chk("dual9_rd1", RD1, 32'hA5A5A5A5);
    chk("dual9_rv0", 32'(RV0), 32'h1);
    chk("dual9_rv1", 32'(RV1), 32'h1);
    chk("dual9_wcount", 32'(WCOUNT), 32'd1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
